// File: rtl/uart_tx_fifo_if.sv
// Host write port, status and transmitter-side signals of the UART TX buffer.
// The master modport is the host/bench side; the slave modport is the buffer.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            ovf_clr;
  logic            baud;
  logic [7:0]      txdata;
  logic            tx_enable;
  logic            busy;

  modport master (
    output wr_data, wr_en, ovf_clr, baud,
    input  full, empty, count, overflow, txdata, tx_enable, busy
  );

  modport slave (
    input  wr_data, wr_en, ovf_clr, baud,
    output full, empty, count, overflow, txdata, tx_enable, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: launches one byte per frame and
// paces launches by counting 10 baud ticks (start + 8 data + stop).
module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           reset_,
  uart_tx_fifo_if.slave  bus
);
  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]     r_count, w_count_nxt;
  logic                r_full, r_empty, r_overflow;
  logic [7:0]          r_txdata, w_txdata_nxt;
  logic                r_tx_enable, w_tx_enable_nxt;
  logic [3:0]          r_bcnt, w_bcnt_nxt;
  logic                w_push, w_pop;

  // full is the pre-edge value, so a write while full is dropped even if a pop
  // frees a slot at the same edge.
  assign w_push      = bus.wr_en && !r_full;
  assign w_count_nxt = r_count + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};

  always_comb begin
    w_state_nxt     = r_state;
    w_tx_enable_nxt = 1'b0;
    w_txdata_nxt    = r_txdata;
    w_bcnt_nxt      = r_bcnt;
    w_pop           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_empty) begin
          w_pop           = 1'b1;
          w_txdata_nxt    = r_mem[r_rd_ptr];
          w_tx_enable_nxt = 1'b1;
          w_bcnt_nxt      = '0;
          w_state_nxt     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The transmitter is still idle during the strobe cycle, so a baud
        // tick there does not belong to the frame.
        if (bus.baud && !r_tx_enable) begin
          if (r_bcnt == 4'd9) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_bcnt_nxt = r_bcnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ST_IDLE;
      r_tx_enable <= 1'b0;
      r_txdata    <= 8'h00;
      r_bcnt      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_enable <= w_tx_enable_nxt;
      r_txdata    <= w_txdata_nxt;
      r_bcnt      <= w_bcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CT);
      r_empty <= (w_count_nxt == '0);
      // A new overflow event wins over a simultaneous clear.
      if (bus.wr_en && r_full) r_overflow <= 1'b1;
      else if (bus.ovf_clr)    r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.txdata    = r_txdata;
  assign bus.tx_enable = r_tx_enable;
  assign bus.busy      = (r_state == ST_BUSY) || !r_empty;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of launched bytes, a
// table-driven fill/overflow sequence and hand-written pacing sequences.
module tb_uart_tx_fifo;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bif();
  uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset_(reset_), .bus(bif));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // baud source: periodic generator OR'd with manual pulses
  bit   baud_on  = 1'b0;
  int   baud_div = 16;
  int   bph      = 0;
  logic r_auto   = 1'b0;
  logic r_man    = 1'b0;
  assign bif.baud = r_auto | r_man;

  always @(posedge clk) begin
    #1;
    if (baud_on) begin
      r_auto = (bph == baud_div - 1);
      bph    = (bph == baud_div - 1) ? 0 : bph + 1;
    end else begin
      r_auto = 1'b0;
      bph    = 0;
    end
  end

  // monitor: scoreboard compare, spacing and serial-line model
  logic [7:0] sb[$];
  int         gaps[$];
  logic       bits[$];
  int         since   = 10;
  int         strobes = 0;
  int         bitn    = 10;
  logic [9:0] shreg   = '0;

  always @(negedge clk) begin
    if (!reset_) begin
      since = 10;
      bitn  = 10;
    end else if (bif.tx_enable) begin
      strobes++;
      chk("launch_spacing_ge_10", 32'(since >= 10), 1);
      gaps.push_back(since);
      since = 0;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe actual txdata=%0h expected no strobe", bif.txdata);
      end else begin
        chk("txdata_order", 32'(bif.txdata), 32'(sb.pop_front()));
      end
      shreg = {1'b1, bif.txdata, 1'b0};
      bitn  = 0;
    end else if (bif.baud) begin
      since++;
      if (bitn < 10) begin
        bits.push_back(shreg[bitn]);
        bitn++;
      end
    end
  end

  task automatic do_reset();
    reset_      = 1'b0;
    bif.wr_en   = 1'b0;
    bif.wr_data = 8'h00;
    bif.ovf_clr = 1'b0;
    baud_on     = 1'b0;
    r_man       = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_ = 1'b1;
    sb.delete(); gaps.delete(); bits.delete();
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_count"},     32'(bif.count), 0);
    chk({p, "_empty"},     32'(bif.empty), 1);
    chk({p, "_full"},      32'(bif.full), 0);
    chk({p, "_overflow"},  32'(bif.overflow), 0);
    chk({p, "_txdata"},    32'(bif.txdata), 0);
    chk({p, "_tx_enable"}, 32'(bif.tx_enable), 0);
    chk({p, "_busy"},      32'(bif.busy), 0);
  endtask

  task automatic wait_strobe(input int target, input string name);
    int c = 0;
    while (strobes < target && c < 3000) begin step(); c++; end
    if (strobes < target) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual strobes=%0d expected %0d", name, strobes, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (bif.busy && c < 3000) begin step(); c++; end
    chk({name, "_idle"}, 32'(bif.busy), 0);
  endtask

  task automatic write_byte(input logic [7:0] d);
    bif.wr_data = d; bif.wr_en = 1'b1;
    sb.push_back(d);
    step();
    bif.wr_en = 1'b0;
  endtask

  typedef struct {
    logic            wr_en;
    logic [7:0]      data;
    logic            clr;
    logic            sbp;
    logic [ADDR_W:0] exp_count;
    logic            exp_full;
    logic            exp_empty;
    logic            exp_ovf;
  } vec_t;

  vec_t tbl[20];
  int   exp_line[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    int s0, s1, n, sent, maxc, c;
    bit done;

    for (int i = 0; i <= 16; i++)
      tbl[i] = '{1'b1, 8'(16 + i), 1'b0, 1'b1, 5'((i == 0) ? 1 : i), (i == 16), 1'b0, 1'b0};
    tbl[17] = '{1'b1, 8'hEE, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 8'hEF, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};

    do_reset();
    check_reset_vals("rst");

    // 1: reset mid-frame
    baud_on = 1'b1; baud_div = 8;
    s0 = strobes;
    write_byte(8'h3C);
    write_byte(8'h5A);
    wait_strobe(s0 + 1, "t1");
    n = 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge clk);
      if (bif.baud && !bif.tx_enable) n++;
    end
    @(posedge clk); #3;
    reset_ = 1'b0;
    #1;
    check_reset_vals("t1_async");
    sb.delete();
    step(); step();
    reset_ = 1'b1;
    s1 = strobes;
    repeat (300) step();
    chk("t1_no_strobe_after_reset", 32'(strobes), 32'(s1));
    chk("t1_count_after_reset", 32'(bif.count), 0);

    // 2: single byte latency, width, serial image
    do_reset();
    baud_on = 1'b1; baud_div = 16;
    s0 = strobes;
    write_byte(8'hA5);
    chk("t2_no_strobe_yet", 32'(bif.tx_enable), 0);
    chk("t2_count_after_write", 32'(bif.count), 1);
    step();
    chk("t2_strobe_2clk", 32'(bif.tx_enable), 1);
    chk("t2_txdata", 32'(bif.txdata), 32'h A5);
    step();
    chk("t2_strobe_width", 32'(bif.tx_enable), 0);
    n = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (bif.baud) begin
        n++;
        if (n == 10) begin
          chk("t2_busy_before_10th", 32'(bif.busy), 1);
          step();
          chk("t2_busy_after_10th", 32'(bif.busy), 0);
          done = 1'b1;
        end
      end
    end
    chk("t2_ten_bauds_seen", 32'(done), 1);
    chk("t2_line_bits", 32'(bits.size()), 10);
    if (bits.size() == 10)
      for (int i = 0; i < 10; i++) chk($sformatf("t2_line_bit%0d", i), 32'(bits[i]), 32'(exp_line[i]));
    chk("t2_txdata_held", 32'(bif.txdata), 32'h A5);

    // 3: burst of three behind a frame in progress
    do_reset();
    baud_on = 1'b1; baud_div = 4;
    s0 = strobes;
    write_byte(8'h00);
    wait_strobe(s0 + 1, "t3_first");
    gaps.delete();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    chk("t3_count3", 32'(bif.count), 3);
    wait_strobe(s0 + 2, "t3_b1"); chk("t3_count2", 32'(bif.count), 2);
    wait_strobe(s0 + 3, "t3_b2"); chk("t3_count1", 32'(bif.count), 1);
    wait_strobe(s0 + 4, "t3_b3"); chk("t3_count0", 32'(bif.count), 0);
    wait_idle("t3");
    chk("t3_gap_entries", 32'(gaps.size()), 3);
    foreach (gaps[i]) chk($sformatf("t3_gap%0d_exact10", i), 32'(gaps[i]), 10);

    // 4: table-driven fill, overflow and clear with transmitter stalled
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bif.wr_en = tbl[i].wr_en; bif.wr_data = tbl[i].data; bif.ovf_clr = tbl[i].clr;
      if (tbl[i].sbp) sb.push_back(tbl[i].data);
      step();
      chk($sformatf("t4_row%0d_count", i), 32'(bif.count), 32'(tbl[i].exp_count));
      chk($sformatf("t4_row%0d_full", i), 32'(bif.full), 32'(tbl[i].exp_full));
      chk($sformatf("t4_row%0d_empty", i), 32'(bif.empty), 32'(tbl[i].exp_empty));
      chk($sformatf("t4_row%0d_overflow", i), 32'(bif.overflow), 32'(tbl[i].exp_ovf));
    end
    bif.wr_en = 1'b0; bif.ovf_clr = 1'b0;
    baud_on = 1'b1; baud_div = 2;
    wait_idle("t4");
    chk("t4_sb_drained", 32'(sb.size()), 0);

    // 5: baud in the strobe cycle is not counted
    do_reset();
    s0 = strobes;
    sb.push_back(8'h81); sb.push_back(8'h42);
    bif.wr_en = 1'b1; bif.wr_data = 8'h81; step();
    bif.wr_data = 8'h42; step();
    bif.wr_en = 1'b0;
    chk("t5_strobe", 32'(bif.tx_enable), 1);
    r_man = 1'b1; step(); r_man = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step(); r_man = 1'b1; step(); r_man = 1'b0;
    end
    chk("t5_no_strobe_after_10_raw", 32'(strobes), 32'(s0 + 1));
    chk("t5_busy_after_10_raw", 32'(bif.busy), 1);
    step(); r_man = 1'b1; step(); r_man = 1'b0;
    chk("t5_no_strobe_on_11th_edge", 32'(bif.tx_enable), 0);
    step();
    chk("t5_strobe_after_11_raw", 32'(bif.tx_enable), 1);
    chk("t5_second_txdata", 32'(bif.txdata), 32'h42);
    baud_on = 1'b1; baud_div = 3;
    wait_idle("t5");

    // 6: 40 bytes through the wrapping pointers
    do_reset();
    baud_on = 1'b1; baud_div = 2;
    s0 = strobes; sent = 0; maxc = 0; c = 0;
    while (sent < 40 && c < 5000) begin
      if (!bif.full) begin
        bif.wr_en = 1'b1; bif.wr_data = 8'(sent * 7 + 3);
        sb.push_back(8'(sent * 7 + 3));
        sent++;
      end else begin
        bif.wr_en = 1'b0;
      end
      step(); c++;
      if (int'(bif.count) > maxc) maxc = int'(bif.count);
    end
    bif.wr_en = 1'b0;
    chk("t6_sent", 32'(sent), 40);
    wait_strobe(s0 + 40, "t6");
    wait_idle("t6");
    chk("t6_strobes", 32'(strobes - s0), 40);
    chk("t6_sb_drained", 32'(sb.size()), 0);
    chk("t6_max_count_le_depth", 32'(maxc <= DEPTH), 1);
    chk("t6_no_overflow", 32'(bif.overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
